// File: rtl/tx_ltssm_multirate.sv
// TX-side LTSSM: follows the state commanded by the main LTSSM, drives detect,
// electrical-idle and ordered-set requests, and reports TX exit conditions back.
module tx_ltssm_multirate #(
    parameter int LANESNUMBER         = 16,
    parameter int MAX_GEN             = 3,
    parameter int DETECT_QUIET_CYCLES = 24000,
    parameter int DETECT_WAIT_CYCLES  = 64,
    parameter int POLL_ACTIVE_OS      = 1024,
    parameter int CFG_OS              = 16,
    parameter int SPEED_CYCLES        = 256
) (
    input  logic                               Pclk,
    input  logic                               Reset,
    input  logic [3:0]                         SetTXState,
    input  logic [2:0]                         TargetRate,
    output logic                               TXFinishFlag,
    output logic [3:0]                         TXExitTo,
    output logic [2:0]                         Gen,
    output logic                               SpeedChange,
    input  logic [LANESNUMBER-1:0]             DetectStatus,
    output logic [LANESNUMBER-1:0]             DetectReq,
    output logic [LANESNUMBER-1:0]             ElecIdleReq,
    output logic [LANESNUMBER-1:0]             DetectLanes,
    output logic [$clog2(LANESNUMBER+1)-1:0]   NumberDetectLanes,
    output logic                               WriteDetectLanesFlag,
    output logic [1:0]                         OSType,
    output logic                               OSGeneratorStart,
    input  logic                               OSGeneratorBusy,
    input  logic                               OSGeneratorFinish,
    output logic                               HoldFIFOData,
    output logic                               MuxSel,
    output logic                               turnOff
);

    localparam int NLW     = $clog2(LANESNUMBER+1);
    localparam int MAX_A   = (DETECT_QUIET_CYCLES > DETECT_WAIT_CYCLES) ? DETECT_QUIET_CYCLES : DETECT_WAIT_CYCLES;
    localparam int MAX_CYC = (MAX_A > SPEED_CYCLES) ? MAX_A : SPEED_CYCLES;
    localparam int TW      = $clog2(MAX_CYC+1);

    typedef enum logic [3:0] {
        DETECT_QUIET    = 4'd0,
        DETECT_ACTIVE   = 4'd1,
        POLLING_ACTIVE  = 4'd2,
        POLLING_CONFIG  = 4'd3,
        CFG_LW_START    = 4'd4,
        CFG_LW_ACCEPT   = 4'd5,
        CFG_LN_WAIT     = 4'd6,
        CFG_LN_ACTIVE   = 4'd7,
        CFG_COMPLETE    = 4'd8,
        CFG_IDLE        = 4'd9,
        L0              = 4'd10,
        REC_RCVR_LOCK   = 4'd11,
        REC_RCVR_CFG    = 4'd12,
        REC_SPEED       = 4'd13,
        REC_IDLE        = 4'd14,
        IDLE            = 4'd15
    } state_t;

    state_t                 state;
    state_t                 ns;
    state_t                 exit_target;
    logic                   entry;
    logic                   hs_state;
    logic                   exit_cond;
    logic                   lanes_write;
    logic                   speed_ok;
    logic                   rate_valid;
    logic [TW-1:0]          timer;
    logic [10:0]            os_count;
    logic                   outstanding;
    logic                   exit_done;

    logic [1:0]             nxt_os_type;
    logic                   nxt_mux;
    logic                   nxt_speed;
    logic [LANESNUMBER-1:0] nxt_elec;
    logic [LANESNUMBER-1:0] nxt_det_req;

    always_ff @(posedge Pclk) begin
        if (Reset) state <= IDLE;
        else       state <= ns;
    end

    // Exit conditions are judged on the current state; the per-state outputs
    // are derived from the incoming state so they line up with the state register.
    always_comb begin
        ns          = state_t'(SetTXState);
        entry       = (ns != state);
        hs_state    = 1'b0;
        exit_cond   = 1'b0;
        exit_target = DETECT_QUIET;
        lanes_write = 1'b0;
        rate_valid  = (TargetRate != 3'd0) && (int'(TargetRate) <= MAX_GEN);
        speed_ok    = (TargetRate > Gen) && (int'(TargetRate) <= MAX_GEN);

        case (state)
            DETECT_QUIET: begin
                if (int'(timer) == DETECT_QUIET_CYCLES-1) begin
                    exit_cond   = 1'b1;
                    exit_target = DETECT_ACTIVE;
                end
            end
            DETECT_ACTIVE: begin
                if (int'(timer) == DETECT_WAIT_CYCLES-1) begin
                    exit_cond = 1'b1;
                    if (DetectStatus != '0) begin
                        lanes_write = 1'b1;
                        exit_target = POLLING_ACTIVE;
                    end else begin
                        exit_target = DETECT_QUIET;
                    end
                end
            end
            POLLING_ACTIVE: begin
                hs_state = 1'b1;
                if (int'(os_count) >= POLL_ACTIVE_OS) begin
                    exit_cond   = 1'b1;
                    exit_target = POLLING_CONFIG;
                end
            end
            POLLING_CONFIG: begin
                hs_state = 1'b1;
                if (int'(os_count) >= CFG_OS) begin
                    exit_cond   = 1'b1;
                    exit_target = CFG_LW_START;
                end
            end
            CFG_LW_START, CFG_LW_ACCEPT, CFG_LN_WAIT, CFG_LN_ACTIVE, REC_RCVR_LOCK: begin
                hs_state = 1'b1;
            end
            CFG_COMPLETE: begin
                hs_state = 1'b1;
                if (int'(os_count) >= CFG_OS) begin
                    exit_cond   = 1'b1;
                    exit_target = CFG_IDLE;
                end
            end
            CFG_IDLE, REC_IDLE: begin
                hs_state = 1'b1;
                if (int'(os_count) >= CFG_OS) begin
                    exit_cond   = 1'b1;
                    exit_target = L0;
                end
            end
            REC_RCVR_CFG: begin
                hs_state = 1'b1;
                if (SpeedChange && int'(os_count) >= CFG_OS) begin
                    exit_cond   = 1'b1;
                    exit_target = REC_SPEED;
                end
            end
            REC_SPEED: begin
                if (int'(timer) == SPEED_CYCLES-1) begin
                    exit_cond   = 1'b1;
                    exit_target = REC_RCVR_LOCK;
                end
            end
            default: ;
        endcase

        nxt_os_type = 2'b00;
        nxt_mux     = 1'b0;
        nxt_speed   = 1'b0;
        nxt_elec    = '0;
        nxt_det_req = '0;
        case (ns)
            DETECT_QUIET:  nxt_elec    = {LANESNUMBER{1'b1}};
            DETECT_ACTIVE: nxt_det_req = {LANESNUMBER{1'b1}};
            REC_SPEED:     nxt_elec    = {LANESNUMBER{1'b1}};
            POLLING_CONFIG, CFG_COMPLETE: nxt_os_type = 2'b01;
            CFG_IDLE, REC_IDLE:           nxt_os_type = 2'b10;
            L0:            nxt_mux     = 1'b1;
            REC_RCVR_LOCK: nxt_speed   = speed_ok;
            REC_RCVR_CFG: begin
                nxt_os_type = 2'b01;
                nxt_speed   = speed_ok;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Pclk) begin
        if (Reset) begin
            timer                <= '0;
            os_count             <= '0;
            outstanding          <= 1'b0;
            exit_done            <= 1'b0;
            OSGeneratorStart     <= 1'b0;
            TXFinishFlag         <= 1'b0;
            TXExitTo             <= 4'd0;
            Gen                  <= 3'd1;
            DetectLanes          <= '0;
            WriteDetectLanesFlag <= 1'b0;
        end else if (entry) begin
            timer                <= '0;
            os_count             <= '0;
            outstanding          <= 1'b0;
            exit_done            <= 1'b0;
            OSGeneratorStart     <= 1'b0;
            TXFinishFlag         <= 1'b0;
            WriteDetectLanesFlag <= 1'b0;
        end else begin
            OSGeneratorStart     <= 1'b0;
            TXFinishFlag         <= 1'b0;
            WriteDetectLanesFlag <= 1'b0;
            if (timer != '1) timer <= timer + 1'b1;

            if (hs_state && OSGeneratorFinish) begin
                outstanding <= 1'b0;
                if (os_count != '1) os_count <= os_count + 1'b1;
            end else if (hs_state && !OSGeneratorBusy && !outstanding) begin
                OSGeneratorStart <= 1'b1;
                outstanding      <= 1'b1;
            end

            if (exit_cond && !exit_done) begin
                exit_done    <= 1'b1;
                TXFinishFlag <= 1'b1;
                TXExitTo     <= exit_target;
                if (lanes_write) begin
                    DetectLanes          <= DetectStatus;
                    WriteDetectLanesFlag <= 1'b1;
                end
                if (state == REC_SPEED && rate_valid) Gen <= TargetRate;
            end
        end
    end

    always_ff @(posedge Pclk) begin
        if (Reset) begin
            OSType       <= 2'b00;
            MuxSel       <= 1'b0;
            HoldFIFOData <= 1'b1;
            turnOff      <= 1'b1;
            SpeedChange  <= 1'b0;
            ElecIdleReq  <= {LANESNUMBER{1'b1}};
            DetectReq    <= '0;
        end else begin
            OSType       <= nxt_os_type;
            MuxSel       <= nxt_mux;
            HoldFIFOData <= !nxt_mux;
            turnOff      <= !nxt_mux;
            SpeedChange  <= nxt_speed;
            ElecIdleReq  <= nxt_elec;
            DetectReq    <= nxt_det_req;
        end
    end

    always_comb begin
        NumberDetectLanes = '0;
        for (int i = 0; i < LANESNUMBER; i++) begin
            if (DetectLanes[i]) NumberDetectLanes = NLW'(i + 1);
        end
    end

endmodule
